// File: rtl/program_state_tracker.sv
// Program-state holder: publishes {priv, isa_c, mode, asid} with a generation tag and runs a
// flush handshake on changes that invalidate fetch/translation state. Optional: PS_ASID_FLUSH_EN.
module program_state_tracker #(
  parameter int unsigned ASID_W = 9,
  parameter int unsigned GEN_W  = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [1:0]        i_priv,
  input  logic              i_isa_c,
  input  logic [31:0]       i_satp,
  input  logic              i_update,
  input  logic              i_flush_ack,
  output logic [ASID_W+3:0] o_ps,
  output logic [GEN_W-1:0]  o_ps_gen,
  output logic              o_flush_req,
  output logic              o_stall,
  input  logic [31:0]       i_log_fd
);

  localparam logic [ASID_W+3:0] PS_RST = {2'b11, 1'b1, 1'b0, {ASID_W{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SETTLE} state_t;

  state_t            r_state;
  logic [ASID_W+3:0] r_ps;
  logic [ASID_W+3:0] r_pend;
  logic [GEN_W-1:0]  r_gen;
  logic              r_flush_req;
  logic              r_stall;

  logic [ASID_W+3:0] w_ns;
  logic [ASID_W+3:0] w_commit_val;
  logic              w_flush_diff;
  logic              w_commit;
  logic              w_unused;

  assign w_unused = ^{i_satp, i_log_fd};

  always_comb begin
    w_ns = {i_priv, i_isa_c, i_satp[31], i_satp[22 +: ASID_W]};
`ifdef PS_ASID_FLUSH_EN
    w_flush_diff = (w_ns != r_ps);
`else
    w_flush_diff = (w_ns[ASID_W+3:ASID_W] != r_ps[ASID_W+3:ASID_W]);
`endif
    w_commit     = 1'b0;
    w_commit_val = w_ns;
    case (r_state)
      // an update landing with the ack wins over the held pending value
      S_REQ: begin
        w_commit = i_flush_ack;
        if (!i_update) w_commit_val = r_pend;
      end
      default: w_commit = i_update && !w_flush_diff && (w_ns != r_ps);
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_ps        <= PS_RST;
      r_pend      <= PS_RST;
      r_gen       <= '0;
      r_flush_req <= 1'b0;
      r_stall     <= 1'b0;
    end else begin
      if (w_commit) begin
        r_ps  <= w_commit_val;
        r_gen <= r_gen + 1'b1;
      end
      case (r_state)
        S_IDLE, S_SETTLE: begin
          r_state <= S_IDLE;
          r_stall <= 1'b0;
          if (i_update && w_flush_diff) begin
            r_pend      <= w_ns;
            r_state     <= S_REQ;
            r_flush_req <= 1'b1;
            r_stall     <= 1'b1;
          end
        end
        S_REQ: begin
          if (i_flush_ack) begin
            r_state     <= S_SETTLE;
            r_flush_req <= 1'b0;
          end else if (i_update) begin
            r_pend <= w_ns;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ps        = r_ps;
  assign o_ps_gen    = r_gen;
  assign o_flush_req = r_flush_req;
  assign o_stall     = r_stall;

`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_commit)
      $display("ps commit old=%h new=%h gen=%0d", r_ps, w_commit_val,
               GEN_W'(r_gen + 1'b1));
  end
`endif

endmodule

// File: tb/tb_program_state_tracker.sv
// Randomised and directed bench for program_state_tracker against a behavioural model.
module tb_program_state_tracker;

    localparam int ASID_W = 9;
    localparam int GEN_W  = 3;
    localparam int PSW    = ASID_W + 4;
    localparam int OBSW   = PSW + GEN_W + 2;
    localparam logic [PSW-1:0] PS_RST = {2'b11, 1'b1, 1'b0, {ASID_W{1'b0}}};

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      priv = 2'b11;
    logic            isa_c = 1'b1;
    logic [31:0]     satp = '0;
    logic            update = 1'b0;
    logic            ack = 1'b0;
    logic [PSW-1:0]  ps;
    logic [GEN_W-1:0] gen;
    logic            req;
    logic            stall;

    int checks = 0;
    int errors = 0;

    logic [PSW-1:0]  m_ps;
    logic [PSW-1:0]  m_pend;
    int              m_gen;
    bit              m_req;
    bit              m_settle;

    logic [OBSW-1:0] obs;
    logic [OBSW-1:0] exp_v;

    assign obs = {ps, gen, req, stall};

    program_state_tracker #(.ASID_W(ASID_W), .GEN_W(GEN_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_priv(priv), .i_isa_c(isa_c), .i_satp(satp),
        .i_update(update), .i_flush_ack(ack), .o_ps(ps), .o_ps_gen(gen),
        .o_flush_req(req), .o_stall(stall), .i_log_fd(32'h0000_0001)
    );

    always #5 clk = ~clk;

    function automatic logic [PSW-1:0] mk(int p, int c, int m, int a);
        return {2'(p), 1'(c), 1'(m), ASID_W'(a)};
    endfunction

    function automatic logic [OBSW-1:0] pack(logic [PSW-1:0] p, int g, bit r, bit s);
        return {p, GEN_W'(g), r, s};
    endfunction

    function automatic bit flush_class(logic [PSW-1:0] a, logic [PSW-1:0] b);
`ifdef PS_ASID_FLUSH_EN
        return a != b;
`else
        return a[PSW-1:ASID_W] != b[PSW-1:ASID_W];
`endif
    endfunction

    task automatic model_reset();
        m_ps = PS_RST; m_pend = PS_RST; m_gen = 0; m_req = 0; m_settle = 0;
    endtask

    task automatic drive(int p, int c, int m, int a);
        priv = 2'(p);
        isa_c = 1'(c);
        satp = {1'(m), 9'(a), 22'($urandom)};
        update = 1'b1;
    endtask

    // One clock: advance the model with the inputs seen at the edge, then clear strobes.
    task automatic cyc();
        logic [PSW-1:0] n;
        @(posedge clk);
        n = {priv, isa_c, satp[31], satp[22 +: ASID_W]};
        if (rst_n) begin
            if (m_req) begin
                if (ack) begin
                    m_ps = update ? n : m_pend;
                    m_gen = (m_gen + 1) % (1 << GEN_W);
                    m_req = 0;
                    m_settle = 1;
                end else if (update) begin
                    m_pend = n;
                end
            end else begin
                m_settle = 0;
                if (update && flush_class(n, m_ps)) begin
                    m_pend = n;
                    m_req = 1;
                end else if (update && n != m_ps) begin
                    m_ps = n;
                    m_gen = (m_gen + 1) % (1 << GEN_W);
                end
            end
        end
        #1;
        update = 1'b0;
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        exp_v = pack(13'h1C00, 0, 0, 0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset: got %h expected %h", obs, exp_v); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_idle: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_flush_basic();
        drive(0, 1, 0, 0);
        exp_v = pack(13'h1C00, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL flush_req_c%0d: got %h expected %h", i, obs, exp_v); end
        end
        ack = 1'b1;
        cyc();
        exp_v = pack(13'h0400, 1, 0, 1);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL flush_commit: got %h expected %h", obs, exp_v); end
        cyc();
        exp_v = pack(13'h0400, 1, 0, 0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL settle_done: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_req_overwrite();
        drive(2, 1, 0, 0);
        cyc();
        exp_v = pack(13'h0400, 1, 1, 1);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL overwrite_req: got %h expected %h", obs, exp_v); end
        drive(0, 1, 1, 0);
        cyc();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL overwrite_hold: got %h expected %h", obs, exp_v); end
        ack = 1'b1;
        cyc();
        exp_v = pack(13'h0600, 2, 0, 1);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL overwrite_commit: got %h expected %h", obs, exp_v); end
        exp_v = pack(13'h0600, 2, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL single_flush_%0d: got %h expected %h", i, obs, exp_v); end
        end
    endtask

    task automatic test_asid_only();
        int asids[2] = '{5, 7};
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, asids[i]);
            cyc();
`ifdef PS_ASID_FLUSH_EN
            exp_v = pack(mk(0, 1, 1, (i == 0) ? 0 : 5), 2 + i, 1, 1);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL asid_req_%0d: got %h expected %h", i, obs, exp_v); end
            ack = 1'b1;
            cyc();
            exp_v = pack(mk(0, 1, 1, asids[i]), 3 + i, 0, 1);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL asid_commit_%0d: got %h expected %h", i, obs, exp_v); end
            cyc();
`endif
            exp_v = pack(mk(0, 1, 1, asids[i]), 3 + i, 0, 0);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL asid_only_%0d: got %h expected %h", i, obs, exp_v); end
        end
    endtask

    task automatic test_gen_wrap();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(3, 1, 0, i + 1);
            cyc();
`ifdef PS_ASID_FLUSH_EN
            ack = 1'b1;
            cyc();
            cyc();
`endif
            exp_v = pack(mk(3, 1, 0, i + 1), (i + 1) % 8, 0, 0);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL gen_step_%0d: got %h expected %h", i, obs, exp_v); end
        end
        drive(3, 1, 0, 8);
        cyc();
        exp_v = pack(mk(3, 1, 0, 8), 0, 0, 0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL no_change: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_stray_ack();
        exp_v = pack(mk(3, 1, 0, 8), 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            ack = 1'b1;
            cyc();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL stray_ack_%0d: got %h expected %h", i, obs, exp_v); end
        end
    endtask

    task automatic test_reset_mid_req();
        drive(1, 0, 0, 8);
        cyc();
        exp_v = pack(mk(3, 1, 0, 8), 0, 1, 1);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL mid_req: got %h expected %h", obs, exp_v); end
        #2;
        rst_n = 1'b0;
        #1;
        exp_v = pack(13'h1C00, 0, 0, 0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL async_reset: got %h expected %h", obs, exp_v); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL pending_discarded: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_random();
        int p, c, m;
        for (int i = 0; i < 400; i++) begin
            p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'(m_ps[PSW-1:PSW-2]);
            c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : int'(m_ps[PSW-3]);
            m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : int'(m_ps[PSW-4]);
            drive(p, c, m, int'($urandom_range(0, 2)));
            update = 1'($urandom_range(0, 1));
            ack = ($urandom_range(0, 3) == 0);
            cyc();
            exp_v = pack(m_ps, m_gen, m_req, m_req || m_settle);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL random_%0d: got %h expected %h", i, obs, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_flush_basic();
        test_req_overwrite();
        test_asid_only();
        test_gen_wrap();
        test_stray_ack();
        test_reset_mid_req();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
